// File: rtl/noise_test_pkg.sv
// Shared constants and state encoding for the noise test receive path.
package noise_test_pkg;

  localparam int FRAME_LEN_DEF = 1000;
  localparam int CNT_W_DEF     = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/noise_rx_checker_if.sv
// Stream inputs, control and latched results of the noise receive checker.
interface noise_rx_checker_if
  import noise_test_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             rx_in;
  logic             ref_in;
  logic             frame_en;
  logic             clear;
  logic             busy;
  logic             done;
  logic             short_frame;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output rx_in, ref_in, frame_en, clear,
    input  busy, done, short_frame, err_count, bit_count, first_err_idx
  );

  modport slave (
    input  rx_in, ref_in, frame_en, clear,
    output busy, done, short_frame, err_count, bit_count, first_err_idx
  );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous bit through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/noise_rx_checker.sv
// Compares the returned noise-channel stream against the clean reference over one
// frame and latches error count, bit count and first error index.
module noise_rx_checker
  import noise_test_pkg::*;
#(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  noise_rx_checker_if.slave   bus
);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  logic rx_s, ref_s, en_s;
  logic en_prev_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic primed, rise, mism, cmp;

  state_t state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d, bit_q, bit_d, first_q, first_d;
  logic [CNT_W-1:0] base_err, base_bit, base_first;
  logic short_q, short_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rx  (.clk(clk), .rst(rst), .d_i(bus.rx_in),    .q_o(rx_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ref (.clk(clk), .rst(rst), .d_i(bus.ref_in),   .q_o(ref_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_en  (.clk(clk), .rst(rst), .d_i(bus.frame_en), .q_o(en_s));

  // The synchronizer chains hold reset zeros until refilled; keep en_prev pinned high
  // until then so an enable already high across reset never looks like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q   <= '0;
      en_prev_q <= 1'b1;
    end else begin
      prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      en_prev_q <= primed ? en_s : 1'b1;
    end
  end

  assign primed = prime_q[SYNC_STAGES-1];
  assign rise   = primed & en_s & ~en_prev_q;
  assign mism   = rx_s ^ ref_s;

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= '0;
      bit_q   <= '0;
      first_q <= '1;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      first_q <= first_d;
      short_q <= short_d;
    end
  end

  // Next state: the rising-edge cycle restarts the results and compares bit 0.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    bit_d      = bit_q;
    first_d    = first_q;
    short_d    = short_q;
    base_err   = err_q;
    base_bit   = bit_q;
    base_first = first_q;
    cmp        = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      err_d   = '0;
      bit_d   = '0;
      first_d = '1;
      short_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          cmp        = 1'b1;
          base_err   = '0;
          base_bit   = '0;
          base_first = '1;
          short_d    = 1'b0;
        end
        RUN: if (en_s) begin
          cmp = 1'b1;
        end else begin
          state_d = DONE;
          short_d = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (cmp) begin
        bit_d   = base_bit + 1'b1;
        err_d   = mism ? sat_inc(base_err) : base_err;
        first_d = (mism && (base_first == '1)) ? base_bit : base_first;
        state_d = (bit_d == FRAME_LEN_C) ? DONE : RUN;
      end
    end
  end

  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.short_frame   = short_q;
  assign bus.err_count     = err_q;
  assign bus.bit_count     = bit_q;
  assign bus.first_err_idx = first_q;
endmodule

// File: tb/tb_noise_rx_checker.sv
module tb_noise_rx_checker;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  noise_rx_checker_if #(.CNT_W(CNT_W)) nif ();

  noise_rx_checker #(.FRAME_LEN(1000), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(nif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (nif.done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n bits with frame_en high; bits at e0/e1/e2 have rx inverted.
  task automatic drive_bits(input int n, input int e0, input int e1, input int e2);
    for (int i = 0; i < n; i++) begin
      nif.frame_en = 1'b1;
      nif.ref_in   = (i % 2) == 1;
      nif.rx_in    = ((i % 2) == 1) ^ ((i == e0) || (i == e1) || (i == e2));
      tick();
    end
  endtask

  task automatic end_frame();
    nif.frame_en = 1'b0;
    nif.rx_in    = 1'b0;
    nif.ref_in   = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (nif.busy !== 1'b0)          begin n_bad++; $display("FAIL rst_busy: got %b expected 0", nif.busy); end
    n_cmp++; if (nif.done !== 1'b0)          begin n_bad++; $display("FAIL rst_done: got %b expected 0", nif.done); end
    n_cmp++; if (nif.short_frame !== 1'b0)   begin n_bad++; $display("FAIL rst_short: got %b expected 0", nif.short_frame); end
    n_cmp++; if (nif.err_count !== 10'd0)    begin n_bad++; $display("FAIL rst_err: got %0d expected 0", nif.err_count); end
    n_cmp++; if (nif.bit_count !== 10'd0)    begin n_bad++; $display("FAIL rst_bits: got %0d expected 0", nif.bit_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd1023) begin n_bad++; $display("FAIL rst_first: got %0d expected 1023", nif.first_err_idx); end
  endtask

  task automatic test_clean();
    int d0 = done_cnt;
    drive_bits(1000, -1, -1, -1);
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL clean_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.err_count !== 10'd0)     begin n_bad++; $display("FAIL clean_err: got %0d expected 0", nif.err_count); end
    n_cmp++; if (nif.bit_count !== 10'd1000)  begin n_bad++; $display("FAIL clean_bits: got %0d expected 1000", nif.bit_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd1023) begin n_bad++; $display("FAIL clean_first: got %0d expected 1023", nif.first_err_idx); end
    n_cmp++; if (nif.short_frame !== 1'b0)    begin n_bad++; $display("FAIL clean_short: got %b expected 0", nif.short_frame); end
    n_cmp++; if (nif.busy !== 1'b0)           begin n_bad++; $display("FAIL clean_busy: got %b expected 0", nif.busy); end
  endtask

  task automatic test_errors();
    int d0 = done_cnt;
    drive_bits(1000, 5, 6, 700);
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL err_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.err_count !== 10'd3)     begin n_bad++; $display("FAIL err_count: got %0d expected 3", nif.err_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd5) begin n_bad++; $display("FAIL err_first: got %0d expected 5", nif.first_err_idx); end
    n_cmp++; if (nif.bit_count !== 10'd1000)  begin n_bad++; $display("FAIL err_bits: got %0d expected 1000", nif.bit_count); end
    n_cmp++; if (nif.short_frame !== 1'b0)    begin n_bad++; $display("FAIL err_short: got %b expected 0", nif.short_frame); end
  endtask

  task automatic test_short_frame();
    int d0 = done_cnt;
    drive_bits(400, 10, 200, -1);
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL short_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.short_frame !== 1'b1)    begin n_bad++; $display("FAIL short_flag: got %b expected 1", nif.short_frame); end
    n_cmp++; if (nif.bit_count !== 10'd400)   begin n_bad++; $display("FAIL short_bits: got %0d expected 400", nif.bit_count); end
    n_cmp++; if (nif.err_count !== 10'd2)     begin n_bad++; $display("FAIL short_err: got %0d expected 2", nif.err_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd10) begin n_bad++; $display("FAIL short_first: got %0d expected 10", nif.first_err_idx); end
  endtask

  task automatic test_overlong();
    int d0 = done_cnt;
    drive_bits(1200, 1100, -1, -1);
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL long_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.busy !== 1'b0)           begin n_bad++; $display("FAIL long_busy: got %b expected 0", nif.busy); end
    n_cmp++; if (nif.bit_count !== 10'd1000)  begin n_bad++; $display("FAIL long_bits: got %0d expected 1000", nif.bit_count); end
    n_cmp++; if (nif.err_count !== 10'd0)     begin n_bad++; $display("FAIL long_err: got %0d expected 0", nif.err_count); end
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL long_done_after: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.short_frame !== 1'b0)    begin n_bad++; $display("FAIL long_short: got %b expected 0", nif.short_frame); end
  endtask

  task automatic test_reset_mid_frame();
    int d0 = done_cnt;
    drive_bits(300, 20, -1, -1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive_bits(300, 50, -1, -1);
    n_cmp++; if (done_cnt - d0 !== 0)         begin n_bad++; $display("FAIL rmid_done: got %0d expected 0", done_cnt - d0); end
    n_cmp++; if (nif.busy !== 1'b0)           begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", nif.busy); end
    n_cmp++; if (nif.bit_count !== 10'd0)     begin n_bad++; $display("FAIL rmid_bits: got %0d expected 0", nif.bit_count); end
    n_cmp++; if (nif.err_count !== 10'd0)     begin n_bad++; $display("FAIL rmid_err: got %0d expected 0", nif.err_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd1023) begin n_bad++; $display("FAIL rmid_first: got %0d expected 1023", nif.first_err_idx); end
    end_frame();
    d0 = done_cnt;
    drive_bits(1000, 0, -1, -1);
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL rmid_next_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.bit_count !== 10'd1000)  begin n_bad++; $display("FAIL rmid_next_bits: got %0d expected 1000", nif.bit_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd0) begin n_bad++; $display("FAIL rmid_next_first: got %0d expected 0", nif.first_err_idx); end
  endtask

  task automatic test_clear_on_edge();
    int d0 = done_cnt;
    // frame_en rises now; its synchronized edge is acted on two edges later.
    nif.frame_en = 1'b1;
    nif.rx_in    = 1'b1;
    nif.ref_in   = 1'b0;
    tick();
    tick();
    nif.clear = 1'b1;
    tick();
    nif.clear = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    n_cmp++; if (nif.busy !== 1'b0)           begin n_bad++; $display("FAIL clr_busy: got %b expected 0", nif.busy); end
    n_cmp++; if (nif.bit_count !== 10'd0)     begin n_bad++; $display("FAIL clr_bits: got %0d expected 0", nif.bit_count); end
    n_cmp++; if (nif.err_count !== 10'd0)     begin n_bad++; $display("FAIL clr_err: got %0d expected 0", nif.err_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd1023) begin n_bad++; $display("FAIL clr_first: got %0d expected 1023", nif.first_err_idx); end
    n_cmp++; if (done_cnt - d0 !== 0)         begin n_bad++; $display("FAIL clr_done: got %0d expected 0", done_cnt - d0); end
    end_frame();
    d0 = done_cnt;
    drive_bits(1000, 999, -1, -1);
    end_frame();
    n_cmp++; if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL clr_next_done: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (nif.err_count !== 10'd1)     begin n_bad++; $display("FAIL clr_next_err: got %0d expected 1", nif.err_count); end
    n_cmp++; if (nif.first_err_idx !== 10'd999) begin n_bad++; $display("FAIL clr_next_first: got %0d expected 999", nif.first_err_idx); end
    n_cmp++; if (nif.bit_count !== 10'd1000)  begin n_bad++; $display("FAIL clr_next_bits: got %0d expected 1000", nif.bit_count); end
  endtask

  initial begin
    nif.rx_in    = 1'b0;
    nif.ref_in   = 1'b0;
    nif.frame_en = 1'b0;
    nif.clear    = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    test_clean();
    test_errors();
    test_short_frame();
    test_overlong();
    test_reset_mid_frame();
    test_clear_on_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
